waka_scan: RTL and testbench

WAKA_SCAN -- requirements
Module: waka_scan

---
 rtl/waka_scan_if.sv | 22 ++
 rtl/waka_scan.sv | 176 +++++++++++++++++
 tb/tb_waka_scan.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waka_scan_if.sv
// Frame-memory read port of the raster scanner.
// The scanner issues reads; the memory answers one clock later.
interface waka_scan_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;

    modport master (
        output mem_re,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_re,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/waka_scan.sv
// Raster scanner: walks frame positions, reads frame memory and
// produces sync/enable/pixel two clocks behind each position.
module waka_scan #(
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int H_ACTIVE = 16,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 12,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 1
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             run,
    waka_scan_if.master      mem,
    output logic             hsync_N,
    output logic             vsync_N,
    output logic             de,
    output logic [PIX_W-1:0] pix,
    output logic             frame_start,
    output logic [7:0]       frame_cnt,
    output logic             busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] h;
    logic [HW-1:0] h_nx;
    logic [VW-1:0] v;
    logic [VW-1:0] v_nx;
    logic          drain_cnt;
    logic          drain_nx;
    logic [7:0]    cnt_nx;

    logic          scanning;
    logic          line_end;
    logic          frame_end;
    logic          in_act;
    logic          in_hs;
    logic          in_vs;
    logic [31:0]   addr_full;

    logic          s1_hs;
    logic          s1_vs;
    logic          s1_fs;

    assign scanning  = (state == ACTIVE);
    assign line_end  = (h == HW'(H_TOTAL - 1));
    assign frame_end = scanning && line_end && (v == VW'(V_TOTAL - 1));

    assign in_act = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign in_hs  = (int'(h) >= HS_LO) && (int'(h) < HS_HI);
    assign in_vs  = (int'(v) >= VS_LO) && (int'(v) < VS_HI);

    assign addr_full = 32'(v) * 32'(H_ACTIVE) + 32'(h);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state     <= IDLE;
            h         <= '0;
            v         <= '0;
            drain_cnt <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            h         <= h_nx;
            v         <= v_nx;
            drain_cnt <= drain_nx;
            frame_cnt <= cnt_nx;
        end
    end

    // run is only honoured in IDLE and at frame end, so frames never truncate
    always_comb begin
        state_nx = state;
        h_nx     = h;
        v_nx     = v;
        drain_nx = drain_cnt;
        cnt_nx   = frame_cnt;
        unique case (state)
            IDLE: begin
                h_nx     = '0;
                v_nx     = '0;
                drain_nx = 1'b0;
                if (run) begin
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (line_end) begin
                    h_nx = '0;
                    v_nx = v + 1'b1;
                end else begin
                    h_nx = h + 1'b1;
                end
                if (frame_end) begin
                    v_nx   = '0;
                    cnt_nx = frame_cnt + 8'd1;
                    if (!run) begin
                        state_nx = DRAIN;
                        drain_nx = 1'b0;
                    end
                end
            end
            DRAIN: begin
                h_nx     = '0;
                v_nx     = '0;
                drain_nx = 1'b1;
                if (drain_cnt) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                h_nx     = '0;
                v_nx     = '0;
                drain_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            mem.mem_re   <= 1'b0;
            mem.mem_addr <= '0;
            s1_hs        <= 1'b0;
            s1_vs        <= 1'b0;
            s1_fs        <= 1'b0;
        end else begin
            mem.mem_re <= scanning && in_act;
            s1_hs      <= scanning && in_hs;
            s1_vs      <= scanning && in_vs;
            s1_fs      <= scanning && (h == '0) && (v == '0);
            if (scanning && in_act) begin
                mem.mem_addr <= addr_full[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            hsync_N     <= 1'b1;
            vsync_N     <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_N     <= !s1_hs;
            vsync_N     <= !s1_vs;
            de          <= mem.mem_re;
            frame_start <= s1_fs;
        end
    end

    // read data arrives in the same cycle de rises, so the pixel is gated here
    assign pix = de ? mem.mem_rdata : '0;

endmodule

// File: tb/tb_waka_scan.sv
// Scoreboard bench for waka_scan: frame-level reference model feeds
// expectation queues, an independent monitor compares every cycle.
module tb_waka_scan;
  logic clk = 1'b0;
  logic rst_N = 1'b0;
  logic run = 1'b0;
  logic rst2_N = 1'b0;
  logic run2 = 1'b0;

  always #5 clk = ~clk;

  waka_scan_if #(.PIX_W(8), .ADDR_W(8)) m ();
  waka_scan_if #(.PIX_W(8), .ADDR_W(8)) m2 ();

  logic hsync_N, vsync_N, de, frame_start, busy;
  logic [7:0] pix, frame_cnt;
  logic hs2, vs2, de2, fs2, busy2;
  logic [7:0] pix2, fc2;

  waka_scan dut (
    .clk(clk), .rst_N(rst_N), .run(run), .mem(m),
    .hsync_N(hsync_N), .vsync_N(vsync_N), .de(de), .pix(pix),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
  );

  waka_scan #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .clk(clk), .rst_N(rst2_N), .run(run2), .mem(m2),
    .hsync_N(hs2), .vsync_N(vs2), .de(de2), .pix(pix2),
    .frame_start(fs2), .frame_cnt(fc2), .busy(busy2)
  );

  always @(posedge clk)
    if (m.mem_re) m.mem_rdata <= m.mem_addr ^ 8'hA5;

  assign m2.mem_rdata = 8'h00;

  typedef struct packed {
    logic       re;
    logic [7:0] addr;
  } mexp_t;

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       de;
    logic [7:0] pix;
    logic       fs;
  } vexp_t;

  typedef struct packed {
    logic       busy;
    logic [7:0] fc;
  } nexp_t;

  mexp_t mq[$];
  vexp_t vq[$];
  nexp_t nq[$];

  int total = 0;
  int bad = 0;

  bit m_scan = 0;
  int m_t = 0;
  int m_drain = 0;
  int m_frames = 0;
  logic [7:0] m_last = 8'h00;

  int re_cnt = 0, busy_cnt = 0, fs_cnt = 0;
  int hs_cnt = 0, vs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected view of frame cycle tt (0..383), straight from the timing rules
  function automatic vexp_t vid(input bit act, input int tt);
    vexp_t e;
    int hh, vv;
    hh = tt % 24;
    vv = tt / 24;
    e.de = act && hh < 16 && vv < 12;
    e.pix = e.de ? (8'(vv * 16 + hh) ^ 8'hA5) : 8'h00;
    e.hs_n = !(act && hh >= 18 && hh < 22);
    e.vs_n = !(act && vv >= 13 && vv < 15);
    e.fs = act && tt == 0;
    return e;
  endfunction

  task automatic model_step();
    vexp_t ve;
    mexp_t me;
    nexp_t ne;
    if (!rst_N) begin
      m_scan = 0;
      m_t = 0;
      m_drain = 0;
      m_frames = 0;
      m_last = 8'h00;
      mq.delete();
      vq.delete();
      nq.delete();
      mq.push_back('{re: 1'b0, addr: 8'h00});
      vq.push_back(vid(1'b0, 0));
      vq.push_back(vid(1'b0, 0));
      return;
    end
    if (m_scan) begin
      if (m_t == 383) begin
        m_frames++;
        if (run) m_t = 0;
        else begin
          m_scan = 0;
          m_drain = 2;
        end
      end else m_t++;
    end else if (m_drain > 0) m_drain--;
    else if (run) begin
      m_scan = 1;
      m_t = 0;
    end
    ve = vid(m_scan, m_t);
    if (ve.de) m_last = 8'((m_t / 24) * 16 + m_t % 24);
    me.re = ve.de;
    me.addr = m_last;
    ne.busy = m_scan || m_drain > 0;
    ne.fc = 8'(m_frames);
    mq.push_back(me);
    vq.push_back(ve);
    nq.push_back(ne);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    mexp_t me;
    vexp_t ve;
    nexp_t ne;
    @(posedge clk);
    #1;
    if (rst_N) begin
      if (mq.size() == 0 || vq.size() == 0 || nq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty at %0t", $time);
      end else begin
        me = mq.pop_front();
        ve = vq.pop_front();
        ne = nq.pop_front();
        chk("mem_re", 32'(m.mem_re), 32'(me.re));
        chk("mem_addr", 32'(m.mem_addr), 32'(me.addr));
        chk("hsync_N", 32'(hsync_N), 32'(ve.hs_n));
        chk("vsync_N", 32'(vsync_N), 32'(ve.vs_n));
        chk("de", 32'(de), 32'(ve.de));
        chk("pix", 32'(pix), 32'(ve.pix));
        chk("frame_start", 32'(frame_start), 32'(ve.fs));
        chk("busy", 32'(busy), 32'(ne.busy));
        chk("frame_cnt", 32'(frame_cnt), 32'(ne.fc));
      end
      if (m.mem_re === 1'b1) re_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (hsync_N === 1'b0) hs_cnt++;
      if (vsync_N === 1'b0) vs_cnt++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_re"}, 32'(m.mem_re), 32'd0);
    chk({tag, "_addr"}, 32'(m.mem_addr), 32'd0);
    chk({tag, "_hs"}, 32'(hsync_N), 32'd1);
    chk({tag, "_vs"}, 32'(vsync_N), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_pix"}, 32'(pix), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fc"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (!m_scan && m_drain == 0) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_idle: timeout after %0d clocks", limit);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pos(input int limit, input int tmin);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (m_scan && m_t >= tmin) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_pos: t=%0d never reached", tmin);
    end
  endtask

  task automatic wait_frames(input int limit, input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (m_frames >= target) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_frames: frame %0d never reached", target);
    end
  endtask

  initial begin
    int s_re, s_busy, s_fs, s_hs, s_vs;
    int n_fs, n_de, n_re, n_hs, n_vs;

    rst_N = 1'b0;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst_N = 1'b1;
    repeat (5) @(negedge clk);

    // one-clock run request: exactly one frame
    s_re = re_cnt;
    s_busy = busy_cnt;
    run = 1'b1;
    @(negedge clk) run = 1'b0;
    wait_idle(600);
    chk("single_re", 32'(re_cnt - s_re), 32'd192);
    chk("single_busy", 32'(busy_cnt - s_busy), 32'd386);
    chk("single_fc", 32'(frame_cnt), 32'd1);

    // run dropped at line 5 still completes the frame
    s_re = re_cnt;
    s_busy = busy_cnt;
    run = 1'b1;
    wait_pos(600, 5 * 24);
    run = 1'b0;
    wait_idle(600);
    chk("stop_re", 32'(re_cnt - s_re), 32'd192);
    chk("stop_busy", 32'(busy_cnt - s_busy), 32'd386);
    chk("stop_fc", 32'(frame_cnt), 32'd2);

    // three back-to-back frames
    s_re = re_cnt;
    s_busy = busy_cnt;
    s_fs = fs_cnt;
    s_hs = hs_cnt;
    s_vs = vs_cnt;
    run = 1'b1;
    wait_frames(1500, m_frames + 2);
    run = 1'b0;
    wait_idle(600);
    chk("cont_re", 32'(re_cnt - s_re), 32'd576);
    chk("cont_busy", 32'(busy_cnt - s_busy), 32'd1154);
    chk("cont_fs", 32'(fs_cnt - s_fs), 32'd3);
    chk("cont_hs", 32'(hs_cnt - s_hs), 32'd192);
    chk("cont_vs", 32'(vs_cnt - s_vs), 32'd144);

    // reset in the middle of line 7
    run = 1'b1;
    wait_pos(600, 7 * 24 + 5);
    @(posedge clk);
    #3 rst_N = 1'b0;
    #1 chk_reset("midrst");
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_N = 1'b1;
    s_re = re_cnt;
    repeat (500) @(negedge clk);
    chk("rst_quiet_re", 32'(re_cnt - s_re), 32'd0);

    // release with run already high starts at once
    rst_N = 1'b0;
    run = 1'b1;
    repeat (2) @(negedge clk);
    rst_N = 1'b1;
    @(posedge clk);
    #1 chk("release_busy", 32'(busy), 32'd1);

    // random run toggling
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) run = ~run;
    end
    run = 1'b0;
    wait_idle(1000);

    // 256 frames on a small raster: 8 x 5 lines = 40 clocks per frame
    n_fs = 0;
    n_de = 0;
    n_re = 0;
    n_hs = 0;
    n_vs = 0;
    @(negedge clk) rst2_N = 1'b1;
    @(negedge clk) run2 = 1'b1;
    for (int i = 0; i < 256 * 40; i++) begin
      @(posedge clk);
      #1;
      if (fs2 === 1'b1) n_fs++;
      if (de2 === 1'b1) n_de++;
      if (m2.mem_re === 1'b1) n_re++;
      if (hs2 === 1'b0) n_hs++;
      if (vs2 === 1'b0) n_vs++;
      if (i == 128 * 40) chk("wrap_fc_mid", 32'(fc2), 32'd128);
      if (i == 256 * 40 - 1) chk("wrap_fc_255", 32'(fc2), 32'd255);
    end
    @(posedge clk);
    #1;
    chk("wrap_fc_zero", 32'(fc2), 32'd0);
    chk("wrap_fs_count", 32'(n_fs), 32'd256);
    chk("wrap_de_count", 32'(n_de), 32'd2048);
    chk("wrap_re_count", 32'(n_re), 32'd2048);
    chk("wrap_vs_count", 32'(n_vs), 32'd2048);
    chk("wrap_hs_count", 32'(n_hs), 32'(255 * 10 + 9));
    chk("wrap_busy", 32'(busy2), 32'd1);
    chk("wrap_pix", 32'(pix2), 32'd0);
    @(negedge clk) run2 = 1'b0;
    repeat (50) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
